// File: rtl/conv_pe_acc_pkg.sv
// Shared types for the convolution PE accumulator.
// Holds FSM encodings and the row tag carried down the dot pipeline.
package conv_pe_acc_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic first;
    logic last;
  } row_tag_t;

endpackage

// File: rtl/conv_pe_acc_dot.sv
// Tap shift registers, product stage and row-sum stage.
// A row tag rides along with each accepted row.
module pe_dot_pipe
  import conv_pe_acc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 5,
  parameter int SUM_W  = 2*DATA_W+$clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_we,
  input  logic [DATA_W-1:0]        w_in,
  input  logic                     if_we,
  input  logic [DATA_W-1:0]        if_in,
  input  logic                     flush,
  input  logic                     in_valid,
  input  row_tag_t                 in_tag,
  output logic                     out_valid,
  output row_tag_t                 out_tag,
  output logic signed [SUM_W-1:0]  out_sum
);

  localparam int PROD_W = 2*DATA_W;

  logic signed [DATA_W-1:0] w_tap [TAPS];
  logic signed [DATA_W-1:0] f_tap [TAPS];
  logic signed [PROD_W-1:0] prod  [TAPS];
  logic                     prod_v;
  row_tag_t                 prod_tag;
  logic signed [SUM_W-1:0]  sum_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) begin
        w_tap[i] <= '0;
        f_tap[i] <= '0;
      end
    end else begin
      if (w_we) begin
        w_tap[0] <= w_in;
        for (int i = 1; i < TAPS; i++)
          w_tap[i] <= w_tap[i-1];
      end
      if (if_we) begin
        f_tap[0] <= if_in;
        for (int i = 1; i < TAPS; i++)
          f_tap[i] <= f_tap[i-1];
      end
    end
  end

  // Products see the pre-edge taps even when a write lands on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prod_v   <= 1'b0;
      prod_tag <= '0;
      for (int i = 0; i < TAPS; i++)
        prod[i] <= '0;
    end else begin
      prod_v <= in_valid & ~flush;
      if (in_valid) begin
        prod_tag <= in_tag;
        for (int i = 0; i < TAPS; i++)
          prod[i] <= w_tap[i] * f_tap[i];
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < TAPS; i++)
      sum_c = sum_c + SUM_W'(prod[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_sum   <= '0;
    end else begin
      out_valid <= prod_v & ~flush;
      if (prod_v) begin
        out_tag <= prod_tag;
        out_sum <= sum_c;
      end
    end
  end

endmodule

// File: rtl/conv_pe_acc.sv
// Convolution PE: accumulates ROWS row dot products per window,
// then requantises and holds the result on a valid/ready output.
module conv_pe_acc
  import conv_pe_acc_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TAPS      = 5,
  parameter int ROWS      = 5,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_we,
  input  logic [DATA_W-1:0] w_in,
  input  logic              if_we,
  input  logic [DATA_W-1:0] if_in,
  input  logic              mac_valid,
  output logic              mac_ready,
  input  logic              acc_clr,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ACC_W-1:0]  acc_out
);

  localparam int SUM_W = 2*DATA_W+$clog2(TAPS);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        row_cnt;
  logic                    accept, last_row, relu_q;
  row_tag_t                tag, s_tag;
  logic                    s_valid;
  logic signed [SUM_W-1:0] s_sum;
  logic signed [ACC_W-1:0] acc, acc_n;

  function automatic logic [OUT_W-1:0] requant(
    input logic signed [ACC_W-1:0] a,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (relu && s < 0) s = '0;
    if (s > OUT_MAX) s = OUT_MAX;
    if (s < OUT_MIN) s = OUT_MIN;
    return s[OUT_W-1:0];
  endfunction

  assign mac_ready = (state == ST_ACCUM);
  assign accept    = mac_valid & mac_ready & ~acc_clr;
  assign last_row  = (row_cnt == CNT_W'(ROWS-1));
  assign tag       = '{first: (row_cnt == '0), last: last_row};
  assign acc_n     = s_tag.first ? ACC_W'(s_sum)
                                 : acc + ACC_W'(s_sum);

  pe_dot_pipe #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .SUM_W  (SUM_W)
  ) u_dot (
    .clk       (clk),
    .rst       (rst),
    .w_we      (w_we),
    .w_in      (w_in),
    .if_we     (if_we),
    .if_in     (if_in),
    .flush     (acc_clr),
    .in_valid  (accept),
    .in_tag    (tag),
    .out_valid (s_valid),
    .out_tag   (s_tag),
    .out_sum   (s_sum)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_ACCUM: if (accept && last_row) state_n = ST_DRAIN;
      ST_DRAIN: if (s_valid && s_tag.last) state_n = ST_HOLD;
      ST_HOLD:  if (out_valid && out_ready) state_n = ST_ACCUM;
      default:  state_n = ST_ACCUM;
    endcase
    if (acc_clr) state_n = ST_ACCUM;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_ACCUM;
      row_cnt   <= '0;
      relu_q    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc_out   <= '0;
    end else begin
      state <= state_n;
      if (acc_clr) begin
        row_cnt   <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept) begin
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
          if (last_row) relu_q <= relu_en;
        end
        if (s_valid) begin
          acc <= acc_n;
          if (s_tag.last) begin
            out_valid <= 1'b1;
            acc_out   <= acc_n;
            out_data  <= requant(acc_n, relu_q);
          end
        end else if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_pe_acc.sv
// Self-checking bench for conv_pe_acc: vector table, corner
// sequences and randomized traffic against a window-level model.
module tb_conv_pe_acc;

  localparam int DW = 8;
  localparam int T  = 5;
  localparam int R  = 5;
  localparam int AW = 32;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_we = 1'b0, if_we = 1'b0;
  logic [DW-1:0] w_in = '0, if_in = '0;
  logic          mac_valid = 1'b0, acc_clr = 1'b0;
  logic          relu_en = 1'b0, out_ready = 1'b0;
  logic          mac_ready, out_valid, mac_ready2, out_valid2;
  logic [OW-1:0] out_data, out_data2;
  logic [AW-1:0] acc_out, acc_out2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  conv_pe_acc #(.DATA_W(DW), .TAPS(T), .ROWS(R), .ACC_W(AW),
                .OUT_W(OW), .OUT_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_in(w_in),
    .if_we(if_we), .if_in(if_in), .mac_valid(mac_valid),
    .mac_ready(mac_ready), .acc_clr(acc_clr), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .acc_out(acc_out));

  conv_pe_acc #(.DATA_W(DW), .TAPS(T), .ROWS(R), .ACC_W(AW),
                .OUT_W(OW), .OUT_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .w_we(w_we), .w_in(w_in),
    .if_we(if_we), .if_in(if_in), .mac_valid(mac_valid),
    .mac_ready(mac_ready2), .acc_clr(acc_clr), .relu_en(relu_en),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .acc_out(acc_out2));

  // Window-level reference model
  int     mw [T];
  int     mf [T];
  longint m_sum, m_acc;
  int     m_rows, m_cd, m_o0, m_o2;
  bit     m_busy, m_ov, m_relu;

  function automatic int rq(longint a, int sh, bit r);
    longint s;
    longint hi = (64'sd1 <<< (OW-1)) - 1;
    s = a >>> sh;
    if (r && s < 0) s = 0;
    if (s > hi) s = hi;
    if (s < -hi-1) s = -hi-1;
    return int'(s);
  endfunction

  task automatic chk(string n, longint a, longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  task automatic cyc();
    longint dot;
    bit     take;
    if (!rst) begin
      for (int i = 0; i < T; i++) begin mw[i] = 0; mf[i] = 0; end
      m_rows = 0; m_cd = 0; m_busy = 0; m_ov = 0;
      m_acc = 0; m_o0 = 0; m_o2 = 0;
    end else begin
      take = mac_valid && !m_busy && !acc_clr;
      dot = 0;
      for (int i = 0; i < T; i++)
        dot += longint'(mw[i]) * longint'(mf[i]);
      if (acc_clr) begin
        m_rows = 0; m_busy = 0; m_cd = 0; m_ov = 0;
      end else begin
        if (m_ov && out_ready) begin m_ov = 0; m_busy = 0; end
        if (m_cd > 0) begin
          m_cd--;
          if (m_cd == 0) m_ov = 1;
        end
        if (take) begin
          m_sum = (m_rows == 0) ? dot : m_sum + dot;
          m_rows++;
          if (m_rows == R) begin
            m_rows = 0; m_busy = 1; m_cd = 2;
            m_relu = relu_en;
            m_acc = longint'(int'(m_sum));
            m_o0 = rq(m_acc, 0, m_relu);
            m_o2 = rq(m_acc, 2, m_relu);
          end
        end
      end
      if (w_we) begin
        for (int i = T-1; i > 0; i--) mw[i] = mw[i-1];
        mw[0] = int'($signed(w_in));
      end
      if (if_we) begin
        for (int i = T-1; i > 0; i--) mf[i] = mf[i-1];
        mf[0] = int'($signed(if_in));
      end
    end
    @(posedge clk);
    #1;
    chk("m_ready", mac_ready, !m_busy);
    chk("m_ready2", mac_ready2, !m_busy);
    chk("m_ovalid", out_valid, m_ov);
    chk("m_ovalid2", out_valid2, m_ov);
    if (m_ov) begin
      chk("m_acc", longint'($signed(acc_out)), m_acc);
      chk("m_acc2", longint'($signed(acc_out2)), m_acc);
      chk("m_out", longint'($signed(out_data)), m_o0);
      chk("m_out2", longint'($signed(out_data2)), m_o2);
    end
  endtask

  task automatic idle();
    w_we = 0; if_we = 0; mac_valid = 0;
    acc_clr = 0; out_ready = 0;
  endtask

  task automatic load(logic [T-1:0][DW-1:0] w,
                      logic [T-1:0][DW-1:0] f);
    for (int i = 0; i < T; i++) begin
      w_we = 1; w_in = w[i];
      if_we = 1; if_in = f[i];
      cyc();
    end
    w_we = 0; if_we = 0;
  endtask

  task automatic run_window(string n);
    mac_valid = 1;
    repeat (R) cyc();
    mac_valid = 0;
    cyc();
    chk({n, "_lat1"}, out_valid, 0);
    cyc();
    chk({n, "_lat2"}, out_valid, 1);
  endtask

  task automatic handshake(string n);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk({n, "_hs_valid"}, out_valid, 0);
    chk({n, "_hs_ready"}, mac_ready, 1);
  endtask

  typedef struct packed {
    logic [T-1:0][DW-1:0] w;
    logic [T-1:0][DW-1:0] f;
    logic                 relu;
    logic signed [31:0]   acc;
    logic signed [7:0]    o0;
    logic signed [7:0]    o2;
  } vec_t;

  vec_t tbl [4];
  logic [T-1:0][DW-1:0] w_ramp, all_one, all_max;

  initial begin
    w_ramp  = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    all_one = {T{8'd1}};
    all_max = {T{8'd127}};

    tbl[0] = '{w: w_ramp, f: all_one, relu: 1'b0,
               acc: 32'sd75, o0: 8'sd75, o2: 8'sd18};
    tbl[1] = '{w: all_max, f: all_max, relu: 1'b0,
               acc: 32'sd403225, o0: 8'sd127, o2: 8'sd127};
    tbl[2] = '{w: {T{8'h80}}, f: all_max, relu: 1'b0,
               acc: -32'sd406400, o0: -8'sd128, o2: -8'sd128};
    tbl[3] = '{w: {T{8'h80}}, f: all_max, relu: 1'b1,
               acc: -32'sd406400, o0: 8'sd0, o2: 8'sd0};

    // Reset with inputs toggling
    rst = 0;
    repeat (3) begin
      w_we = 1'($urandom); w_in = 8'($urandom);
      if_we = 1'($urandom); if_in = 8'($urandom);
      mac_valid = 1'($urandom); out_ready = 1'($urandom);
      cyc();
    end
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_acc", acc_out, 0);
    idle();
    rst = 1;
    cyc();
    chk("rst_ready", mac_ready, 1);
    run_window("rst_taps");
    chk("rst_taps_acc", acc_out, 0);
    handshake("rst");

    // Vector table
    for (int k = 0; k < 4; k++) begin
      idle();
      relu_en = tbl[k].relu;
      load(tbl[k].w, tbl[k].f);
      run_window($sformatf("v%0d", k));
      chk($sformatf("v%0d_acc", k),
          longint'($signed(acc_out)), tbl[k].acc);
      chk($sformatf("v%0d_out", k),
          longint'($signed(out_data)), tbl[k].o0);
      chk($sformatf("v%0d_out2", k),
          longint'($signed(out_data2)), tbl[k].o2);
      handshake($sformatf("v%0d", k));
    end
    relu_en = 0;

    // Stall in HOLD, mac_valid ignored
    load(w_ramp, all_one);
    run_window("hold");
    mac_valid = 1;
    repeat (4) begin
      cyc();
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 75);
      chk("hold_acc", acc_out, 75);
      chk("hold_ready", mac_ready, 0);
    end
    mac_valid = 0;
    handshake("hold");

    // Abort after 3 rows, then clr together with mac_valid
    load(all_max, all_max);
    mac_valid = 1;
    repeat (3) cyc();
    mac_valid = 0;
    acc_clr = 1;
    cyc();
    acc_clr = 0;
    repeat (4) begin
      cyc();
      chk("clr_no_out", out_valid, 0);
    end
    load(w_ramp, all_one);
    acc_clr = 1; mac_valid = 1;
    cyc();
    acc_clr = 0;
    run_window("clr");
    chk("clr_acc", acc_out, 75);
    handshake("clr");

    // Tap write on the same edge as an accept
    load(w_ramp, all_one);
    mac_valid = 1; w_we = 1; w_in = 8'd10;
    cyc();
    w_we = 0;
    repeat (R-1) cyc();
    mac_valid = 0;
    cyc();
    cyc();
    chk("shift_valid", out_valid, 1);
    chk("shift_acc", acc_out, 111);
    handshake("shift");

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      w_we      = ($urandom_range(3) == 0);
      w_in      = 8'($urandom);
      if_we     = ($urandom_range(3) == 0);
      if_in     = 8'($urandom);
      mac_valid = ($urandom_range(3) != 0);
      acc_clr   = ($urandom_range(49) == 0);
      relu_en   = 1'($urandom);
      out_ready = ($urandom_range(2) == 0);
      cyc();
    end
    idle();
    out_ready = 1;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
